// File: rtl/pacman_sprite_pkg.sv
// Shared types and geometry constants for the Pac-Man sprite engine.
// Build option: define SPRITE_SCALE2_EN to render both sprites at 16x16
// (each ROM texel covers a 2x2 screen block). Otherwise sprites are native 8x8.
package pacman_sprite_pkg;

  // Pac-Man facing direction, encoded as driven by the game logic.
  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_UP    = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  // Mouth animation state.
  typedef enum logic {
    OPEN   = 1'b0,
    CLOSED = 1'b1
  } mouth_t;

`ifdef SPRITE_SCALE2_EN
  // 16x16 on screen; row/col come from dx/dy bits [3:1].
  localparam int SPRITE_SIZE  = 16;
  localparam int SPRITE_SHIFT = 1;
`else
  // Native 8x8; row/col come from dx/dy bits [2:0].
  localparam int SPRITE_SIZE  = 8;
  localparam int SPRITE_SHIFT = 0;
`endif

  // Reverse a 3-bit ROM index (used for bit 7-col and vertical flip 7-row).
  function automatic logic [2:0] flip3(input logic [2:0] v);
    return 3'd7 - v;
  endfunction

endpackage

// File: rtl/sprite_hit_calc.sv
// Combinational hit test for one sprite: offset of the scan position from the
// sprite's top-left corner, in-box flag, and the 3-bit ROM row/column.
// The subtraction is one bit wider than the coordinates so that positions left
// of / above the sprite come out negative instead of wrapping around.
// Build option: SPRITE_SCALE2_EN (via pacman_sprite_pkg) selects 16x16 size.
module sprite_hit_calc
  import pacman_sprite_pkg::*;
#(
  parameter int COORD_W = 10
) (
  input  logic [COORD_W-1:0] i_draw_x,
  input  logic [COORD_W-1:0] i_draw_y,
  input  logic [COORD_W-1:0] i_pos_x,
  input  logic [COORD_W-1:0] i_pos_y,
  output logic               o_hit,
  output logic [2:0]         o_row,
  output logic [2:0]         o_col
);

  localparam logic [COORD_W-1:0] SIZE_C = COORD_W'(SPRITE_SIZE);

  logic [COORD_W:0] w_dx;
  logic [COORD_W:0] w_dy;
  logic             w_x_in;
  logic             w_y_in;

  assign w_dx = {1'b0, i_draw_x} - {1'b0, i_pos_x};
  assign w_dy = {1'b0, i_draw_y} - {1'b0, i_pos_y};

  // Sign bit clear means the scan position is at or right of / below the corner.
  assign w_x_in = ~w_dx[COORD_W] && (w_dx[COORD_W-1:0] < SIZE_C);
  assign w_y_in = ~w_dy[COORD_W] && (w_dy[COORD_W-1:0] < SIZE_C);

  assign o_hit = w_x_in && w_y_in;
  assign o_row = w_dy[SPRITE_SHIFT+2:SPRITE_SHIFT];
  assign o_col = w_dx[SPRITE_SHIFT+2:SPRITE_SHIFT];

endmodule

// File: rtl/pacman_sprite_engine.sv
// Per-pixel Pac-Man / ghost sprite renderer.
//   Stage 1: hit tests, row/col, direction and mouth state are registered;
//            ROM row addresses are driven from these registers.
//   Stage 2: the combinational ROM rows are sampled, the column bit picked
//            according to direction/mouth state, and the pixel flags registered.
// DrawX/DrawY presented in cycle N produce pixel outputs in cycle N+2.
// Build option: SPRITE_SCALE2_EN renders both sprites at 16x16 (same latency/ports).
module pacman_sprite_engine
  import pacman_sprite_pkg::*;
#(
  parameter int ANIM_FRAMES = 8,
  parameter int COORD_W     = 10
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic [COORD_W-1:0] pac_x,
  input  logic [COORD_W-1:0] pac_y,
  input  logic [1:0]         pac_dir,
  input  logic               pac_moving,
  input  logic [COORD_W-1:0] ghost_x,
  input  logic [COORD_W-1:0] ghost_y,
  output logic [2:0]         pac_rom_addr,
  input  logic [7:0]         pac_right_data,
  input  logic [7:0]         pac_closed_data,
  input  logic [7:0]         pac_up_data,
  output logic [2:0]         ghost_rom_addr,
  input  logic [7:0]         ghost_data,
  output logic               pac_pixel,
  output logic               ghost_pixel,
  output logic               sprite_on,
  output logic               sprite_sel,
  output logic               mouth_open
);

  // Last counter value before the mouth toggles.
  localparam logic [7:0] ANIM_LAST = 8'(ANIM_FRAMES - 1);

  // ---------------------------------------------------------------------------
  // Hit calculators (combinational, ahead of stage 1)
  // ---------------------------------------------------------------------------
  logic       w_pac_hit;
  logic [2:0] w_pac_row;
  logic [2:0] w_pac_col;
  logic       w_ghost_hit;
  logic [2:0] w_ghost_row;
  logic [2:0] w_ghost_col;

  sprite_hit_calc #(
    .COORD_W (COORD_W)
  ) u_pac_hit (
    .i_draw_x (DrawX),
    .i_draw_y (DrawY),
    .i_pos_x  (pac_x),
    .i_pos_y  (pac_y),
    .o_hit    (w_pac_hit),
    .o_row    (w_pac_row),
    .o_col    (w_pac_col)
  );

  sprite_hit_calc #(
    .COORD_W (COORD_W)
  ) u_ghost_hit (
    .i_draw_x (DrawX),
    .i_draw_y (DrawY),
    .i_pos_x  (ghost_x),
    .i_pos_y  (ghost_y),
    .o_hit    (w_ghost_hit),
    .o_row    (w_ghost_row),
    .o_col    (w_ghost_col)
  );

  // ---------------------------------------------------------------------------
  // Mouth animation FSM
  // ---------------------------------------------------------------------------
  mouth_t     r_mouth;
  mouth_t     w_mouth_next;
  logic [7:0] r_frame_cnt;
  logic [7:0] w_frame_cnt_next;

  // FSM state and frame counter registers; Reset has priority over frame_tick.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_mouth     <= OPEN;
      r_frame_cnt <= 8'd0;
    end else begin
      r_mouth     <= w_mouth_next;
      r_frame_cnt <= w_frame_cnt_next;
    end
  end

  // Next-state: count frames while moving, toggle the mouth every ANIM_FRAMES.
  always_comb begin
    w_mouth_next     = r_mouth;
    w_frame_cnt_next = r_frame_cnt;
    if (frame_tick && pac_moving) begin
      if (r_frame_cnt == ANIM_LAST) begin
        w_frame_cnt_next = 8'd0;
        w_mouth_next     = (r_mouth == OPEN) ? CLOSED : OPEN;
      end else begin
        w_frame_cnt_next = r_frame_cnt + 8'd1;
      end
    end
  end

  assign mouth_open = (r_mouth == OPEN);

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  logic       r_s1_pac_hit;
  logic [2:0] r_s1_pac_row;
  logic [2:0] r_s1_pac_col;
  logic       r_s1_ghost_hit;
  logic [2:0] r_s1_ghost_row;
  logic [2:0] r_s1_ghost_col;
  dir_t       r_s1_dir;
  mouth_t     r_s1_mouth;

  // Capture hit test results and the orientation controls for this pixel.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_s1_pac_hit   <= 1'b0;
      r_s1_pac_row   <= 3'd0;
      r_s1_pac_col   <= 3'd0;
      r_s1_ghost_hit <= 1'b0;
      r_s1_ghost_row <= 3'd0;
      r_s1_ghost_col <= 3'd0;
      r_s1_dir       <= DIR_RIGHT;
      r_s1_mouth     <= OPEN;
    end else begin
      r_s1_pac_hit   <= w_pac_hit;
      r_s1_pac_row   <= w_pac_row;
      r_s1_pac_col   <= w_pac_col;
      r_s1_ghost_hit <= w_ghost_hit;
      r_s1_ghost_row <= w_ghost_row;
      r_s1_ghost_col <= w_ghost_col;
      r_s1_dir       <= dir_t'(pac_dir);
      r_s1_mouth     <= r_mouth;
    end
  end

  // ROM addressing: only the open/down frame reads the up ROM upside down.
  always_comb begin
    pac_rom_addr = r_s1_pac_row;
    if ((r_s1_mouth == OPEN) && (r_s1_dir == DIR_DOWN)) begin
      pac_rom_addr = flip3(r_s1_pac_row);
    end
  end

  assign ghost_rom_addr = r_s1_ghost_row;

  // ---------------------------------------------------------------------------
  // Orientation mux (between stage 1 and stage 2)
  // ---------------------------------------------------------------------------
  logic [2:0] w_pac_rev_col;
  logic [2:0] w_ghost_rev_col;
  logic       w_pac_bit;
  logic       w_ghost_bit;

  // Bit 7 of a ROM row is the leftmost column, so unmirrored reads use 7-col.
  assign w_pac_rev_col   = flip3(r_s1_pac_col);
  assign w_ghost_rev_col = flip3(r_s1_ghost_col);

  // Select the ROM and column bit for Pac-Man from direction and mouth state.
  always_comb begin
    w_pac_bit = 1'b0;
    if (r_s1_mouth == OPEN) begin
      case (r_s1_dir)
        DIR_RIGHT: w_pac_bit = pac_right_data[w_pac_rev_col];
        DIR_LEFT:  w_pac_bit = pac_right_data[r_s1_pac_col];
        DIR_UP:    w_pac_bit = pac_up_data[w_pac_rev_col];
        DIR_DOWN:  w_pac_bit = pac_up_data[w_pac_rev_col];
        default:   w_pac_bit = 1'b0;
      endcase
    end else if (r_s1_dir == DIR_LEFT) begin
      w_pac_bit = pac_closed_data[r_s1_pac_col];
    end else begin
      w_pac_bit = pac_closed_data[w_pac_rev_col];
    end
  end

  // Ghost is symmetric in intent and is never mirrored.
  assign w_ghost_bit = ghost_data[w_ghost_rev_col];

  // ---------------------------------------------------------------------------
  // Stage 2 registers (outputs)
  // ---------------------------------------------------------------------------
  logic r_pac_pixel;
  logic r_ghost_pixel;
  logic r_sprite_on;
  logic r_sprite_sel;

  // Register gated pixel flags; the ghost is drawn over Pac-Man.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pac_pixel   <= 1'b0;
      r_ghost_pixel <= 1'b0;
      r_sprite_on   <= 1'b0;
      r_sprite_sel  <= 1'b0;
    end else begin
      r_pac_pixel   <= r_s1_pac_hit && w_pac_bit;
      r_ghost_pixel <= r_s1_ghost_hit && w_ghost_bit;
      r_sprite_on   <= (r_s1_pac_hit && w_pac_bit) || (r_s1_ghost_hit && w_ghost_bit);
      r_sprite_sel  <= r_s1_ghost_hit && w_ghost_bit;
    end
  end

  assign pac_pixel   = r_pac_pixel;
  assign ghost_pixel = r_ghost_pixel;
  assign sprite_on   = r_sprite_on;
  assign sprite_sel  = r_sprite_sel;

endmodule

// File: doc/pacman_sprite_engine.md
# pacman_sprite_engine

Per-pixel sprite renderer that sits directly downstream of the 8x8 sprite ROMs and upstream of the colour mapper. For each scan position it computes Pac-Man and ghost hit tests and ROM row addresses, then samples the combinational ROM rows. It applies direction (mirror/flip) and mouth animation, and emits registered pixel-on flags. A two-stage pipeline keeps ROM lookup off the VGA-counter critical path.

## Interface
- ANIM_FRAMES, 8, frames between mouth open/closed toggles while moving (legal 1..255)
- COORD_W, 10, width of screen coordinates
- Clk  in  1  pixel clock
- Reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse per frame (start of vblank)
- DrawX, DrawY  in  COORD_W  current scan position
- pac_x, pac_y  in  COORD_W  Pac-Man top-left corner
- pac_dir  in  2  0 right, 1 up, 2 left, 3 down
- pac_moving  in  1  animation enable
- ghost_x, ghost_y  in  COORD_W  ghost top-left corner
- pac_rom_addr  out  3  row address shared by right/closed/up ROMs
- pac_right_data, pac_closed_data, pac_up_data  in  8  ROM rows; bit 7 = leftmost column
- ghost_rom_addr  out  3  row address to ghost ROM
- ghost_data  in  8  ghost ROM row
- pac_pixel, ghost_pixel  out  1  sprite pixel lit
- sprite_on  out  1  pac_pixel | ghost_pixel
- sprite_sel  out  1  1 = ghost wins (ghost over Pac-Man)
- mouth_open  out  1  current animation state

## Operation
- Hit test per sprite: dx = DrawX − pos, dy = DrawY − pos, computed COORD_W+1 bits wide. Hit when both are non-negative and < SIZE (8, or 16 scaled). No wrap: a sprite at x=1020 is clipped, never reappears at x=0.
- row/col = dy[2:0]/dx[2:0] (unscaled).
- Pac-Man open frame: right → right ROM, addr=row, bit 7−col; left → right ROM, addr=row, bit col; up → up ROM, addr=row, bit 7−col; down → up ROM, addr=7−row, bit 7−col.
- Pac-Man closed frame: closed ROM for all directions, column mirrored when dir=left, otherwise unmirrored.
- Ghost: addr=row, bit 7−col, never mirrored.
- Outside hit region pixel forced 0; ROM addresses hold stage-1 value (don't-care).
- Animation FSM, states OPEN, CLOSED. Frame counter 8 bits.
- On frame_tick with pac_moving=1: if counter = ANIM_FRAMES−1 → toggle state, counter←0; else counter+1.
- pac_moving=0 → state and counter hold.
- Simultaneous Reset and frame_tick → Reset wins.

## Timing
- Stage 1 (registered): hit flags, row, col, dir, mouth state. ROM addresses driven from stage-1 registers.
- Stage 2 (registered): ROM data sampled, bit selected, outputs registered.
- Latency: DrawX/DrawY at cycle N → pixel outputs valid at cycle N+2. Colour mapper must delay DrawX/DrawY by 2 to match.
- Position/dir changes take effect on the next pixel; no frame-boundary latching (the game updates positions in vblank).
- mouth_open changes the cycle after the toggling frame_tick.
- Reset values: all outputs 0 except mouth_open=1; pipeline registers cleared; FSM OPEN; counter 0.
- Reset mid-frame clears both stages; outputs valid again 2 cycles after Reset deasserts.

## Configuration
- SPRITE_SCALE2_EN defined: both sprites rendered at 16x16. Hit when dx,dy < 16. row=dy[3:1], col=dx[3:1]; down flip and left mirror use the same 3-bit indices.
- Undefined: native 8x8 as above. Latency and ports identical in both builds.

## Structure
- Package pacman_sprite_pkg: dir_t enum (DIR_RIGHT, DIR_UP, DIR_LEFT, DIR_DOWN), mouth_t enum (OPEN, CLOSED), SPRITE_SIZE / SPRITE_SHIFT constants selected by SPRITE_SCALE2_EN.
- Sub-module sprite_hit_calc: combinational dx/dy, hit, row, col for one sprite. Instantiated twice (Pac-Man, ghost).
- Top holds pipeline registers, orientation mux and animation FSM.

## Test plan
- Reset, then pac at (100,50), dir=right, open, DrawY=52, sweep DrawX 98..110 → pac_rom_addr=2. pac_pixel two cycles later follows 01111110 at x=100..107, 0 elsewhere.
- dir=left, same row → pattern mirrored (01111110 symmetric; at row 3, 01111100 → 00111110). dir=down, DrawY=50 → addr=7, data from up ROM row 7 (00011000).
- pac_moving=1, ANIM_FRAMES=2, 4 frame_ticks → mouth_open 1→1→0→0→1. With pac_moving=0, ticks cause no change.
- Ghost at (100,50) overlapping Pac-Man, row 0, x=103 → ghost_pixel=1, sprite_sel=1, sprite_on=1.
- Pac at x=1020 (COORD_W=10), DrawX=0..3 → pac_pixel=0 (no wrap). DrawX=1023 → pixel per column 3.
- Assert Reset mid-sprite at x=103 → outputs 0 next cycle, mouth_open=1, counter restarts from 0.
- With SPRITE_SCALE2_EN, pac at (0,0), DrawX=6,7 → both map to col 3. DrawX=15 lit per col 7; DrawX=16 → 0.
